// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
//   Shares one MAC TX AXIS port among C_NUM_SRC frame sources. Arbitration happens only at
//   frame boundaries. A grant stays locked until the granted source's tlast beat is accepted.
//   A two-entry (main + skid) registered output stage feeds the MAC.
// Parameters
//   C_NUM_SRC   number of sources, 1..8
//   C_ARB_MODE  0 = round-robin, 1 = fixed priority (lowest index wins)
// Ports
//   tx_mac_aclk, tx_mac_reset       clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready per-source AXIS slaves (source i on tdata[8i+7:8i])
//   m_axis_tdata/tvalid/tlast/tready AXIS master towards tx_axis_mac_*
//   grant                           one-hot grant of the locked frame, 0 when idle
//   busy                            high while a frame is locked
module eth_tx_frame_arbiter #(
  parameter int unsigned C_NUM_SRC  = 2,
  parameter int unsigned C_ARB_MODE = 0
) (
  input  logic                   tx_mac_aclk,
  input  logic                   tx_mac_reset,
  input  logic [8*C_NUM_SRC-1:0] s_axis_tdata,
  input  logic [C_NUM_SRC-1:0]   s_axis_tvalid,
  input  logic [C_NUM_SRC-1:0]   s_axis_tlast,
  output logic [C_NUM_SRC-1:0]   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [C_NUM_SRC-1:0]   grant,
  output logic                   busy
);

  localparam int unsigned IdxW = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [IdxW-1:0] gnt_idx_q;
  logic [IdxW-1:0] last_grant_q;
  logic [7:0]      skid_data_q;
  logic            skid_last_q;
  logic            skid_valid_q;
  logic            skid_valid_d;

  logic [IdxW-1:0] win_idx;
  logic            win_found;
  int unsigned     cand;

  logic            acc;
  logic [7:0]      beat_data;
  logic            beat_last;

  // Winner search: RR scans upward from last_grant+1 with wrap, fixed mode from index 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < C_NUM_SRC; k++) begin
      if (C_ARB_MODE == 1) begin
        cand = k;
      end else begin
        cand = (32'(last_grant_q) + 32'd1 + k) % C_NUM_SRC;
      end
      if (!win_found && s_axis_tvalid[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign beat_data = s_axis_tdata[{gnt_idx_q, 3'b000} +: 8];
  assign beat_last = s_axis_tlast[gnt_idx_q];
  assign acc       = (state_q == StBusy) && s_axis_tvalid[gnt_idx_q] && s_axis_tready[gnt_idx_q];
  assign busy      = (state_q == StBusy);

  // Ready is only ever high with the skid empty, so an accepted beat never meets a full skid.
  always_comb begin
    skid_valid_d = skid_valid_q;
    if (m_axis_tready && skid_valid_q) begin
      skid_valid_d = 1'b0;
    end else if (acc && m_axis_tvalid && !m_axis_tready) begin
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge tx_mac_aclk) begin
    if (tx_mac_reset) begin
      state_q       <= StIdle;
      gnt_idx_q     <= '0;
      last_grant_q  <= IdxW'(C_NUM_SRC - 1);
      grant         <= '0;
      s_axis_tready <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      skid_data_q   <= '0;
      skid_last_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
    end else begin
      // Output stage: skid drains first so beat order is preserved.
      if (m_axis_tready && skid_valid_q) begin
        m_axis_tdata  <= skid_data_q;
        m_axis_tlast  <= skid_last_q;
        m_axis_tvalid <= 1'b1;
      end else if (acc && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= beat_data;
        m_axis_tlast  <= beat_last;
        m_axis_tvalid <= 1'b1;
      end else if (acc) begin
        skid_data_q <= beat_data;
        skid_last_q <= beat_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      skid_valid_q <= skid_valid_d;

      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q                <= StBusy;
            gnt_idx_q              <= win_idx;
            grant                  <= '0;
            grant[win_idx]         <= 1'b1;
            s_axis_tready          <= '0;
            s_axis_tready[win_idx] <= ~skid_valid_d;
          end
        end
        StBusy: begin
          if (acc && beat_last) begin
            state_q       <= StIdle;
            last_grant_q  <= gnt_idx_q;
            grant         <= '0;
            s_axis_tready <= '0;
          end else begin
            s_axis_tready[gnt_idx_q] <= ~skid_valid_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: a round-robin and a fixed-priority instance share one set of
// source drivers (sel picks the active one). Expected beats go into exp_q when a frame is issued;
// the monitor pops and compares on every m_axis transfer.
module tb_eth_tx_frame_arbiter;

  typedef struct packed {
    logic       l;
    logic [7:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        m_ready = 1'b1;
  logic        m_ready_rand = 1'b0;
  logic [15:0] s_tdata = '0;
  logic [1:0]  s_tvalid = '0;
  logic [1:0]  s_tlast = '0;

  logic [1:0] rr_tvalid, fp_tvalid, rr_tready, fp_tready, rr_grant, fp_grant;
  logic [7:0] rr_mdata, fp_mdata;
  logic       rr_mvalid, fp_mvalid, rr_mlast, fp_mlast, rr_busy, fp_busy;
  logic [1:0] cur_tready, cur_grant;
  logic [7:0] cur_mdata;
  logic       cur_mvalid, cur_mlast, cur_busy;

  beat_t       src_q[2][$];
  beat_t       exp_q[$];
  int unsigned gap_q[$];
  int unsigned sent[2];
  int unsigned gap_used[2];
  int unsigned gap_at[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
  int unsigned gap_len[2] = '{0, 0};
  int          n_vec = 0;
  int          n_fail = 0;

  always #4 clk = ~clk;

  assign rr_tvalid  = sel ? 2'b00 : s_tvalid;
  assign fp_tvalid  = sel ? s_tvalid : 2'b00;
  assign cur_tready = sel ? fp_tready : rr_tready;
  assign cur_grant  = sel ? fp_grant : rr_grant;
  assign cur_mdata  = sel ? fp_mdata : rr_mdata;
  assign cur_mvalid = sel ? fp_mvalid : rr_mvalid;
  assign cur_mlast  = sel ? fp_mlast : rr_mlast;
  assign cur_busy   = sel ? fp_busy : rr_busy;

  eth_tx_frame_arbiter #(.C_NUM_SRC(2), .C_ARB_MODE(0)) u_rr (
    .tx_mac_aclk   (clk),
    .tx_mac_reset  (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (rr_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (rr_tready),
    .m_axis_tdata  (rr_mdata),
    .m_axis_tvalid (rr_mvalid),
    .m_axis_tlast  (rr_mlast),
    .m_axis_tready (m_ready),
    .grant         (rr_grant),
    .busy          (rr_busy)
  );

  eth_tx_frame_arbiter #(.C_NUM_SRC(2), .C_ARB_MODE(1)) u_fp (
    .tx_mac_aclk   (clk),
    .tx_mac_reset  (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (fp_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (fp_tready),
    .m_axis_tdata  (fp_mdata),
    .m_axis_tvalid (fp_mvalid),
    .m_axis_tlast  (fp_mlast),
    .m_axis_tready (m_ready),
    .grant         (fp_grant),
    .busy          (fp_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic push_src(input int s, input int len, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + 8'(k);
      b.l = (k == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic push_exp(input int len, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = base + 8'(k);
      b.l = (k == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string nm, input int unsigned budget);
    int unsigned n = 0;
    while (!(exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 && !cur_mvalid)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_sent(input string nm, input int s, input int unsigned target);
    int unsigned n = 0;
    while (sent[s] < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < 1000), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  // Source drivers and m_axis_tready: handshakes are sampled at negedge, inputs change at posedge+1.
  initial begin : driver
    logic [1:0] fire;
    for (int i = 0; i < 2; i++) begin
      sent[i]     = 0;
      gap_used[i] = 0;
    end
    forever begin
      @(negedge clk);
      fire = s_tvalid & cur_tready & {2{~rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (fire[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          sent[i]++;
        end
        if (sent[i] != gap_at[i]) gap_used[i] = 0;
        if (sent[i] == gap_at[i] && gap_used[i] < gap_len[i] && src_q[i].size() > 0) begin
          gap_used[i]++;
          s_tvalid[i] = 1'b0;
        end else if (src_q[i].size() > 0) begin
          s_tvalid[i]        = 1'b1;
          s_tdata[8*i +: 8] = src_q[i][0].d;
          s_tlast[i]         = src_q[i][0].l;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
      m_ready = m_ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard monitor; also records idle output cycles between frames.
  initial begin : monitor
    int unsigned idle;
    logic        after_last;
    beat_t       e;
    idle       = 0;
    after_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle       = 0;
        after_last = 1'b0;
      end else if (cur_mvalid && m_ready) begin
        if (after_last) gap_q.push_back(idle);
        idle       = 0;
        after_last = cur_mlast;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL m_beat: got unexpected beat %0h last=%0b, expected none (t=%0t)",
                   cur_mdata, cur_mlast, $time);
        end else begin
          e = exp_q.pop_front();
          chk("m_beat", {23'd0, cur_mlast, cur_mdata}, {23'd0, e.l, e.d});
        end
      end else if (after_last) begin
        idle++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int unsigned base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(cur_grant), 32'd0);
    chk("rst_busy", 32'(cur_busy), 32'd0);
    chk("rst_mvalid", 32'(cur_mvalid), 32'd0);
    chk("rst_tready", 32'(cur_tready), 32'd0);
    chk("rst_mdata", 32'(cur_mdata), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // T1: single 60-byte frame, latency and grant sequence
    push_src(0, 60, 8'h00);
    push_exp(60, 8'h00);
    @(negedge clk);
    chk("t1_grant_c0", 32'(cur_grant), 32'd0);
    chk("t1_mvalid_c0", 32'(cur_mvalid), 32'd0);
    @(negedge clk);
    chk("t1_grant_c1", 32'(cur_grant), 32'd1);
    chk("t1_busy_c1", 32'(cur_busy), 32'd1);
    chk("t1_tready_c1", 32'(cur_tready), 32'd1);
    chk("t1_mvalid_c1", 32'(cur_mvalid), 32'd0);
    @(negedge clk);
    chk("t1_mvalid_c2", 32'(cur_mvalid), 32'd1);
    chk("t1_mdata_c2", 32'(cur_mdata), 32'd0);
    wait_drain("t1_drain", 500);
    chk("t1_grant_end", 32'(cur_grant), 32'd0);
    chk("t1_busy_end", 32'(cur_busy), 32'd0);

    // T2: round-robin alternation from reset, one idle cycle between frames
    do_reset();
    gap_q.delete();
    for (int f = 0; f < 3; f++) begin
      push_src(0, 64, 8'(f * 64));
      push_src(1, 64, 8'(f * 64 + 32));
    end
    for (int f = 0; f < 3; f++) begin
      push_exp(64, 8'(f * 64));
      push_exp(64, 8'(f * 64 + 32));
    end
    wait_drain("t2_drain", 2000);
    chk("t2_gap_count", 32'(gap_q.size()), 32'd5);
    for (int g = 0; g < gap_q.size(); g++) chk("t2_gap_len", 32'(gap_q[g]), 32'd1);

    // T3: 200-byte frame under random backpressure
    m_ready_rand = 1'b1;
    push_src(0, 200, 8'h00);
    push_exp(200, 8'h00);
    wait_drain("t3_drain", 3000);
    m_ready_rand = 1'b0;
    @(negedge clk);

    // T6: reset mid-frame of src1, then src0 must win the first RR tie
    base = sent[1];
    push_src(1, 60, 8'h80);
    push_exp(60, 8'h80);
    wait_sent("t6_reach30", 1, base + 30);
    @(posedge clk);
    #2 rst = 1'b1;
    src_q[0].delete();
    src_q[1].delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_mvalid", 32'(cur_mvalid), 32'd0);
    chk("t6_grant", 32'(cur_grant), 32'd0);
    chk("t6_busy", 32'(cur_busy), 32'd0);
    chk("t6_tready", 32'(cur_tready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    push_src(0, 10, 8'h05);
    push_src(1, 10, 8'h55);
    push_exp(10, 8'h05);
    push_exp(10, 8'h55);
    wait_drain("t6_drain", 500);

    // T4: src0 stalls mid-frame, src1 stays blocked
    base       = sent[0];
    gap_at[0]  = base + 20;
    gap_len[0] = 5;
    push_src(0, 40, 8'h00);
    push_exp(40, 8'h00);
    wait_sent("t4_reach20", 0, base + 20);
    push_src(1, 10, 8'hA0);
    push_exp(10, 8'hA0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_grant_gap", 32'(cur_grant), 32'd1);
      chk("t4_tready1_gap", 32'(cur_tready[1]), 32'd0);
    end
    wait_drain("t4_drain", 500);
    gap_at[0] = 32'hFFFF_FFFF;

    // T5: fixed priority instance
    sel = 1'b1;
    do_reset();
    base = sent[1];
    push_src(1, 30, 8'h40);
    push_src(1, 12, 8'hC0);
    push_exp(30, 8'h40);
    wait_sent("t5_reach10", 1, base + 10);
    push_src(0, 16, 8'h10);
    push_exp(16, 8'h10);
    push_exp(12, 8'hC0);
    @(negedge clk);
    chk("t5_grant_locked", 32'(cur_grant), 32'd2);
    wait_drain("t5_drain", 500);
    // src0 frame leaves last grant at 0: a tie must still go to src0 in fixed mode
    push_src(0, 8, 8'h01);
    push_exp(8, 8'h01);
    wait_drain("t5b_drain1", 200);
    push_src(0, 8, 8'h30);
    push_src(1, 8, 8'h70);
    push_exp(8, 8'h30);
    push_exp(8, 8'h70);
    wait_drain("t5b_drain2", 300);
    sel = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
